// File: rtl/rr_mux_arbiter_if.sv
// Bundle of the requester-bank signals and the arbitrated output channel.
// master drives requests and data; slave is the arbiter side.
interface rr_mux_arbiter_if #(
    parameter int N     = 16,
    parameter int SEL_W = 4
);
    logic [N-1:0]     req;
    logic [N-1:0]     data_in;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             out;
    logic [7:0]       hold_cnt;

    modport master (
        output req, data_in,
        input  grant, sel, valid, out, hold_cnt
    );

    modport slave (
        input  req, data_in,
        output grant, sel, valid, out, hold_cnt
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded tenure.
// It drives the select of an internal 16:1 single-bit data mux.
module rr_mux_arbiter #(
    parameter int N        = 16,
    parameter int SEL_W    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic [0:0]       state_reg, state_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic             valid_reg, valid_next;
    logic [7:0]       hold_reg, hold_next;

    logic [SEL_W-1:0] base;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [N-1:0]     win_onehot;
    logic [SEL_W-1:0] win_off;
    logic [SEL_W-1:0] winner;
    logic             found;
    logic             owner_req;

    // A releasing owner re-arbitrates from owner+1, which is also the new pointer.
    assign base    = (state_reg == GRANT) ? sel_reg + SEL_W'(1) : ptr_reg;
    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[base +: N];

    always_comb begin
        found   = 1'b0;
        win_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found   = 1'b1;
                win_off = SEL_W'(k);
            end
        end
    end

    // N is a power of two, so the select-width add wraps 15 -> 0 for free.
    assign winner = base + win_off;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (winner == SEL_W'(gi));
        end
    endgenerate

    assign owner_req = bus.req[sel_reg];

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        valid_next = valid_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    grant_next = win_onehot;
                    sel_next   = winner;
                    valid_next = 1'b1;
                    hold_next  = 8'd1;
                end else begin
                    grant_next = '0;
                    sel_next   = '0;
                    valid_next = 1'b0;
                    hold_next  = 8'd0;
                end
            end
            default: begin
                if (owner_req && (hold_reg < HOLD_LIM)) begin
                    hold_next = hold_reg + 8'd1;
                end else begin
                    ptr_next = sel_reg + SEL_W'(1);
                    if (found) begin
                        grant_next = win_onehot;
                        sel_next   = winner;
                        hold_next  = 8'd1;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        sel_next   = '0;
                        valid_next = 1'b0;
                        hold_next  = 8'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            valid_reg <= 1'b0;
            hold_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            valid_reg <= valid_next;
            hold_reg  <= hold_next;
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.sel      = sel_reg;
    assign bus.valid    = valid_reg;
    assign bus.hold_cnt = hold_reg;
    assign bus.out      = valid_reg & bus.data_in[sel_reg];
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares the 16:1 single-bit mux channel among 16 requesters.
- Arbitrates requests, holds each grant for a bounded tenure, and drives the 4-bit mux select.
- Contains the 16:1 data mux internally, so downstream logic sees one arbitrated bit plus a valid flag.
- Sits between the requester bank and the single shared serial output line.

Parameters:
- N, 16: number of requesters; fixed at 16 in this revision.
- SEL_W, 4: select width, equal to log2(N).
- HOLD_MAX, 8: maximum consecutive cycles one requester may hold the grant; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i high means requester i wants the channel.
- data_in  input  16  per-requester data bits; bit i is requester i's data.
- grant  output  16  registered one-hot grant; all zeros when no grant is active.
- sel  output  4  registered index of the granted requester; drives the internal mux.
- valid  output  1  registered; high while a grant is active.
- out  output  1  equals data_in[sel] when valid is high, else 0; combinational from the registered sel/valid.
- hold_cnt  output  8  registered tenure counter, for debug and verification.

Behaviour:
- Reset, synchronous, takes precedence over everything:
  - state = IDLE, grant = 0, sel = 0, valid = 0, hold_cnt = 0, priority pointer ptr = 0.
  - Reset asserted mid-grant drops the grant on the next edge. No release bookkeeping is done.
- Priority search:
  - Find the first i with req[i] = 1, scanning from ptr upward and wrapping 15 -> 0.
  - If no request is set, there is no winner.
- State IDLE:
  - Winner found: next edge loads grant = one-hot(winner), sel = winner, valid = 1, hold_cnt = 1; state becomes GRANT.
  - No winner: stay in IDLE with outputs at their reset values.
  - Latency: req rising in cycle k gives a grant visible in cycle k+1.
- State GRANT with current owner c:
  - Continue: if req[c] = 1 and hold_cnt < HOLD_MAX, keep the grant and increment hold_cnt.
  - Release: if req[c] = 0, or hold_cnt = HOLD_MAX with req[c] = 1 (expiry), set ptr = (c+1) mod 16.
  - Re-arbitrate in the same cycle using ptr = c+1. Requester c is included, as the lowest priority.
  - Winner w found: next edge grants w with hold_cnt = 1 and stays in GRANT. There is no idle bubble. This includes w = c when c is the only requester still active on expiry.
  - No winner: next edge returns to IDLE with grant = 0, valid = 0, hold_cnt = 0.
- Invariants:
  - grant is always zero or one-hot.
  - grant[sel] = 1 whenever valid = 1.
  - hold_cnt never exceeds HOLD_MAX.
- Requests are level-sensitive. A requester that drops req while not granted loses nothing; no requests are queued.
- Simultaneous release and new request: the new request takes part in the same-cycle re-arbitration.
- ptr changes only on release or expiry, never on grant.
- out follows data_in changes within the cycle while the grant is held. There is no data registering.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with req = 16'hFFFF, then deassert rst with req = 0.
  - Required: grant = 0, sel = 0, valid = 0, out = 0 throughout.
- Single requester:
  - Stimulus: req = 16'h0008 held for 3 cycles, then 0; data_in = 16'hAAAA.
  - Required: grant = 16'h0008 and sel = 3 one cycle after req rises; out = 1; hold_cnt counts 1, 2, 3; IDLE one cycle after req falls.
- Round-robin rotation:
  - Stimulus: req = 16'h8001 held; each owner drops its bit for one cycle after 2 cycles of tenure.
  - Required: grant alternates 0 -> 15 -> 0 with no idle cycle between owners.
- Tenure expiry:
  - Stimulus: HOLD_MAX = 8, req = 16'h0030 held constantly.
  - Required: requester 4 is granted for exactly 8 cycles, then requester 5 for 8 cycles, then requester 4 again. hold_cnt resets to 1 at each handover.
- Sole requester on expiry:
  - Stimulus: req = 16'h0100 held for 20 cycles.
  - Required: sel = 8 and valid = 1 continuously; hold_cnt wraps 8 -> 1 with no gap in valid.
- Reset mid-grant:
  - Stimulus: assert rst while sel = 5 and valid = 1.
  - Required: valid = 0 and grant = 0 next edge; after release with req = 16'h0021, requester 0 is granted first (ptr = 0).
